// File: rtl/axis_packet_gen.sv
// AXI-Stream packet source: programmable length, gap and count, incrementing payload.
// Optional LFSR tvalid throttling is enabled by defining AXIS_PACKET_GEN_THROTTLE_EN.
module axis_packet_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,
    input  logic [CNT_WIDTH-1:0]  cfg_num_pkts,
    input  logic                  start,
    input  logic                  stop,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] beat;
    logic [GAP_WIDTH-1:0] gap_q;
    logic [GAP_WIDTH-1:0] gap_cnt;
    logic [CNT_WIDTH-1:0] num_q;
    logic                 stop_pend;

    logic [LEN_WIDTH-1:0] len_eff;
    logic [LEN_WIDTH-1:0] beat_next;
    logic [CNT_WIDTH-1:0] pkt_next;
    logic                 run_end;
    logic                 handshake;
    logic                 pace;

`ifdef AXIS_PACKET_GEN_THROTTLE_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11; free-running once out of reset.
    always_ff @(posedge aclk) begin
        if (!aresetn)
            lfsr <= 16'hACE1;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign pace = lfsr[0];
`else
    assign pace = 1'b1;
`endif

    always_comb begin
        len_eff   = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
        beat_next = beat + 1'b1;
        pkt_next  = pkt_count + 1'b1;
        handshake = m_axis_tvalid && m_axis_tready;
        run_end   = ((num_q != '0) && (pkt_next == num_q)) || stop_pend || stop;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= S_IDLE;
            len_q         <= '0;
            beat          <= '0;
            gap_q         <= '0;
            gap_cnt       <= '0;
            num_q         <= '0;
            stop_pend     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pkt_count     <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q         <= len_eff;
                        gap_q         <= cfg_gap;
                        num_q         <= cfg_num_pkts;
                        beat          <= '0;
                        stop_pend     <= 1'b0;
                        pkt_count     <= '0;
                        busy          <= 1'b1;
                        m_axis_tdata  <= '0;
                        m_axis_tvalid <= pace;
                        m_axis_tlast  <= (len_eff == LEN_WIDTH'(1));
                        state         <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (stop)
                        stop_pend <= 1'b1;
                    if (handshake) begin
                        m_axis_tdata <= m_axis_tdata + 1'b1;
                        if (m_axis_tlast) begin
                            pkt_count <= pkt_next;
                            beat      <= '0;
                            if (run_end) begin
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                                busy          <= 1'b0;
                                done          <= 1'b1;
                                state         <= S_DONE;
                            end else if (gap_q != '0) begin
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= (len_q == LEN_WIDTH'(1));
                                gap_cnt       <= gap_q;
                                state         <= S_GAP;
                            end else begin
                                // Back-to-back: next packet's first beat follows directly.
                                m_axis_tvalid <= 1'b1;
                                m_axis_tlast  <= (len_q == LEN_WIDTH'(1));
                            end
                        end else begin
                            beat          <= beat_next;
                            m_axis_tlast  <= (beat_next == len_q - 1'b1);
                            m_axis_tvalid <= pace;
                        end
                    end else if (!m_axis_tvalid) begin
                        m_axis_tvalid <= pace;
                    end
                end

                S_GAP: begin
                    if (stop_pend || stop) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                        if (gap_cnt == GAP_WIDTH'(1)) begin
                            m_axis_tvalid <= pace;
                            state         <= S_SEND;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_packet_gen.sv
// Directed self-checking bench for axis_packet_gen (default build, throttle disabled).
module tb_axis_packet_gen;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [15:0] cfg_len;
    logic [7:0]  cfg_gap;
    logic [15:0] cfg_num_pkts;
    logic        start, stop, m_axis_tready;
    logic        busy, done, m_axis_tvalid, m_axis_tlast;
    logic [15:0] pkt_count, m_axis_tdata;

    logic        start4, stop4, tready4;
    logic        busy4, done4, tvalid4, tlast4;
    logic [15:0] pkt_count4;
    logic [3:0]  tdata4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    axis_packet_gen dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_num_pkts(cfg_num_pkts),
        .start(start), .stop(stop), .busy(busy), .done(done), .pkt_count(pkt_count),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
    );

    axis_packet_gen #(.DATA_WIDTH(4)) dut4 (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_num_pkts(cfg_num_pkts),
        .start(start4), .stop(stop4), .busy(busy4), .done(done4), .pkt_count(pkt_count4),
        .m_axis_tdata(tdata4), .m_axis_tvalid(tvalid4),
        .m_axis_tlast(tlast4), .m_axis_tready(tready4)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] len, input logic [7:0] gap, input logic [15:0] num);
        cfg_len = len; cfg_gap = gap; cfg_num_pkts = num;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick(); tick();
        n_checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, done, pkt_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b l=%b d=%0h busy=%b done=%b cnt=%0d, exp all 0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, done, pkt_count);
        end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_start(16'd4, 8'd0, 16'd2);
        cfg_len = 16'd7; cfg_num_pkts = 16'd5;   // must not affect the running packet set
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy} !== {1'b1, (i % 4 == 3), 16'(i), 1'b1}) begin
                n_fail++;
                $display("FAIL basic_beat %0d: got v=%b l=%b d=%0d busy=%b, exp v=1 l=%b d=%0d busy=1",
                         i, m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, (i % 4 == 3), i);
            end
            tick();
        end
        n_checks++;
        if ({done, busy, m_axis_tvalid, pkt_count} !== {1'b1, 1'b0, 1'b0, 16'd2}) begin
            n_fail++;
            $display("FAIL basic_done: got done=%b busy=%b v=%b cnt=%0d, exp 1 0 0 2",
                     done, busy, m_axis_tvalid, pkt_count);
        end
        tick();
        n_checks++;
        if ({done, pkt_count} !== {1'b0, 16'd2}) begin
            n_fail++;
            $display("FAIL basic_done_pulse: got done=%b cnt=%0d, exp 0 2", done, pkt_count);
        end
    endtask

    task automatic test_gap();
        logic [7:0] vpat;
        int k;
        vpat = 8'b1110_0111;
        k = 0;
        do_start(16'd3, 8'd2, 16'd2);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (m_axis_tvalid !== vpat[7-i]) begin
                n_fail++;
                $display("FAIL gap_tvalid cycle %0d: got %b exp %b", i, m_axis_tvalid, vpat[7-i]);
            end
            if (vpat[7-i]) begin
                n_checks++;
                if (m_axis_tdata !== 16'(k)) begin
                    n_fail++;
                    $display("FAIL gap_tdata beat %0d: got %0d exp %0d", k, m_axis_tdata, k);
                end
                k++;
            end
            tick();
        end
        n_checks++;
        if ({done, pkt_count} !== {1'b1, 16'd2}) begin
            n_fail++;
            $display("FAIL gap_done: got done=%b cnt=%0d, exp 1 2", done, pkt_count);
        end
        tick();
    endtask

    task automatic test_backpressure();
        do_start(16'd4, 8'd0, 16'd1);
        tick();                                  // beat 0 accepted
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, 1'b0, 16'd1}) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: got v=%b l=%b d=%0d, exp v=1 l=0 d=1",
                         i, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
            end
            tick();
        end
        m_axis_tready = 1'b1;
        for (int j = 1; j < 4; j++) begin
            n_checks++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, (j == 3), 16'(j)}) begin
                n_fail++;
                $display("FAIL bp_beat %0d: got v=%b l=%b d=%0d, exp v=1 l=%b d=%0d",
                         j, m_axis_tvalid, m_axis_tlast, m_axis_tdata, (j == 3), j);
            end
            tick();
        end
        n_checks++;
        if ({done, pkt_count, m_axis_tdata} !== {1'b1, 16'd1, 16'd4}) begin
            n_fail++;
            $display("FAIL bp_done: got done=%b cnt=%0d d=%0d, exp 1 1 4", done, pkt_count, m_axis_tdata);
        end
        tick();
    endtask

    task automatic test_stop();
        do_start(16'd5, 8'd0, 16'd0);
        for (int i = 0; i < 15; i++) begin
            n_checks++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, (i % 5 == 4), 16'(i)}) begin
                n_fail++;
                $display("FAIL stop_beat %0d: got v=%b l=%b d=%0d, exp v=1 l=%b d=%0d",
                         i, m_axis_tvalid, m_axis_tlast, m_axis_tdata, (i % 5 == 4), i);
            end
            if (i == 12) stop = 1'b1;
            tick();
            stop = 1'b0;
        end
        n_checks++;
        if ({done, busy, m_axis_tvalid, pkt_count} !== {1'b1, 1'b0, 1'b0, 16'd3}) begin
            n_fail++;
            $display("FAIL stop_done: got done=%b busy=%b v=%b cnt=%0d, exp 1 0 0 3",
                     done, busy, m_axis_tvalid, pkt_count);
        end
        tick();
        // stop during the inter-packet gap ends the run immediately
        do_start(16'd2, 8'd3, 16'd0);
        tick(); tick();
        n_checks++;
        if ({m_axis_tvalid, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL stop_gap_entry: got v=%b busy=%b, exp 0 1", m_axis_tvalid, busy);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if ({done, busy, m_axis_tvalid, pkt_count} !== {1'b1, 1'b0, 1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL stop_gap_done: got done=%b busy=%b v=%b cnt=%0d, exp 1 0 0 1",
                     done, busy, m_axis_tvalid, pkt_count);
        end
        tick();
    endtask

    task automatic test_len1();
        do_start(16'd1, 8'd0, 16'd3);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, 1'b1, 16'(i)}) begin
                n_fail++;
                $display("FAIL len1_beat %0d: got v=%b l=%b d=%0d, exp v=1 l=1 d=%0d",
                         i, m_axis_tvalid, m_axis_tlast, m_axis_tdata, i);
            end
            tick();
        end
        n_checks++;
        if ({done, pkt_count} !== {1'b1, 16'd3}) begin
            n_fail++;
            $display("FAIL len1_done: got done=%b cnt=%0d, exp 1 3", done, pkt_count);
        end
        tick();
        // zero length behaves as a single-beat packet
        do_start(16'd0, 8'd0, 16'd1);
        n_checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, 1'b1, 16'd0}) begin
            n_fail++;
            $display("FAIL len0_beat: got v=%b l=%b d=%0d, exp 1 1 0", m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        tick();
        n_checks++;
        if ({done, pkt_count} !== {1'b1, 16'd1}) begin
            n_fail++;
            $display("FAIL len0_done: got done=%b cnt=%0d, exp 1 1", done, pkt_count);
        end
        tick();
    endtask

    task automatic test_wrap();
        cfg_len = 16'd20; cfg_gap = 8'd0; cfg_num_pkts = 16'd1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if ({tvalid4, tlast4, tdata4} !== {1'b1, (i == 19), 4'(i % 16)}) begin
                n_fail++;
                $display("FAIL wrap_beat %0d: got v=%b l=%b d=%0d, exp v=1 l=%b d=%0d",
                         i, tvalid4, tlast4, tdata4, (i == 19), i % 16);
            end
            tick();
        end
        n_checks++;
        if ({done4, pkt_count4} !== {1'b1, 16'd1}) begin
            n_fail++;
            $display("FAIL wrap_done: got done=%b cnt=%0d, exp 1 1", done4, pkt_count4);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_start(16'd5, 8'd0, 16'd0);
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if ({pkt_count, m_axis_tdata, busy} !== {16'd1, 16'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL rstmid_pre: got cnt=%0d d=%0d busy=%b, exp 1 7 1", pkt_count, m_axis_tdata, busy);
        end
        aresetn = 1'b0;
        tick();
        n_checks++;
        if ({m_axis_tvalid, busy, pkt_count} !== {1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL rstmid_abort: got v=%b busy=%b cnt=%0d, exp 0 0 0", m_axis_tvalid, busy, pkt_count);
        end
        aresetn = 1'b1;
        tick();
        do_start(16'd2, 8'd0, 16'd1);
        n_checks++;
        if ({m_axis_tvalid, m_axis_tdata, busy} !== {1'b1, 16'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL rstmid_restart: got v=%b d=%0d busy=%b, exp 1 0 1", m_axis_tvalid, m_axis_tdata, busy);
        end
        tick(); tick();
        n_checks++;
        if ({done, pkt_count} !== {1'b1, 16'd1}) begin
            n_fail++;
            $display("FAIL rstmid_done: got done=%b cnt=%0d, exp 1 1", done, pkt_count);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0; start = 1'b0; stop = 1'b0; m_axis_tready = 1'b1;
        start4 = 1'b0; stop4 = 1'b0; tready4 = 1'b1;
        cfg_len = '0; cfg_gap = '0; cfg_num_pkts = '0;
        test_reset();
        test_basic();
        test_gap();
        test_backpressure();
        test_stop();
        test_len1();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_packet_gen.md
Name: axis_packet_gen

Overview:
AXI-Stream packet source, the transmit end of the stream interfaces used throughout the core set. It generates packets of programmable length with an incrementing-counter payload and drives tlast on the final beat of each packet. It inserts programmable idle gaps between packets and obeys downstream backpressure. It is used as a traffic source in front of stream slices, FIFOs and checkers.

Parameters:
DATA_WIDTH, 16, tdata width in bits
LEN_WIDTH, 16, width of the packet-length config field
GAP_WIDTH, 8, width of the inter-packet gap config field
CNT_WIDTH, 16, width of the packet-count config field and status counter

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
cfg_len  in  LEN_WIDTH  beats per packet; 0 treated as 1
cfg_gap  in  GAP_WIDTH  idle cycles between packets
cfg_num_pkts  in  CNT_WIDTH  packets per run; 0 = continuous until stop
start  in  1  pulse; begins a run when idle
stop  in  1  pulse; ends a run at the next packet boundary
busy  out  1  high while a run is in progress
done  out  1  one-cycle pulse when a run ends
pkt_count  out  CNT_WIDTH  packets completed in the current/last run
m_axis_tdata  out  DATA_WIDTH  payload
m_axis_tvalid  out  1  valid
m_axis_tlast  out  1  last beat of packet
m_axis_tready  in  1  ready

Behaviour:
- All outputs are registered. Reset values: tvalid=0, tlast=0, tdata=0, busy=0, done=0, pkt_count=0; FSM=IDLE; stop request cleared.
- Reset mid-run: the run aborts at the reset edge and tvalid is 0 in the following cycle. A partial packet is acceptable only under reset.
- Handshake: a beat transfers when tvalid && tready. While tvalid=1 && tready=0, tdata, tlast and tvalid hold stable. tvalid never drops without a handshake.
- Config capture: cfg_len, cfg_gap and cfg_num_pkts are latched when start is accepted. Later changes have no effect until the next run.
- Payload: a data counter clears to 0 on start and increments by 1 per handshake. The counter continues across packets and wraps modulo 2^DATA_WIDTH.
- FSM states:
  - IDLE: start=1 moves to SEND. In the next cycle: tvalid=1, tdata=0, busy=1, pkt_count=0. start in any state other than IDLE is ignored.
  - SEND: beat counter runs from 0 to len-1. tlast=1 when beat==len-1 (len=1 gives tlast on every beat). On the tlast handshake, pkt_count increments, then:
    - end condition (pkt_count+1==num_pkts with num_pkts!=0, or stop pending) → DONE;
    - else if gap>0 → GAP with tvalid=0;
    - else stay in SEND and present the next packet's first beat in the next cycle (back-to-back).
  - GAP: tvalid=0 for exactly gap cycles, then SEND with tvalid=1.
  - DONE: tvalid=0, done=1 for one cycle, busy=0, then IDLE. pkt_count holds its value until the next start.
- stop: latched as pending in any busy state. A packet is never truncated. If stop arrives during GAP, the FSM moves directly to DONE. A stop while IDLE is ignored.
- A stop and a tlast handshake in the same cycle: the run ends after that packet.
- pkt_count wraps modulo 2^CNT_WIDTH in continuous mode.

Optional Feature:
Macro AXIS_PACKET_GEN_THROTTLE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, loaded on reset) advances every cycle.
  - In SEND, after each non-final handshake, tvalid drops if lfsr[0]==0.
  - While tvalid is low in SEND, tvalid reasserts in the first cycle where lfsr[0]==1.
  - The first beat after start or GAP also waits for lfsr[0]==1.
  - Payload, tlast and counts are unchanged.
- Undefined: the LFSR is absent and beats within a packet are presented back-to-back.

Test Plan:
- len=4, gap=0, num=2, tready=1: 8 beats with tdata 0..7, tlast on 3 and 7, done one cycle after beat 7, pkt_count=2.
- len=3, gap=2, num=2, tready=1: tvalid pattern 1,1,1,0,0,1,1,1; tdata 0..5.
- len=4, num=1, tready=0 for 5 cycles at beat 1: tdata=1 with tvalid=1 held for 5 cycles; the remaining beats 1..3 complete; no beat is lost or duplicated.
- len=5, num=0, stop pulsed at beat 2 of packet 3: packet 3 completes (tdata through 14, tlast), done pulses, pkt_count=3.
- len=1, num=3: tlast=1 on every beat, tdata 0,1,2. Also DATA_WIDTH=4, len=20: tdata wraps 15→0.
- aresetn low mid-packet: tvalid=0, busy=0 and pkt_count=0 from the next cycle. A new start restarts with tdata=0.
